// File: rtl/line_fill_engine_pkg.sv
// Shared types and defaults for the cache line fill / writeback engine.
package line_fill_engine_pkg;

  localparam int WORDS_DEF  = 4;
  localparam int RD_LAT_DEF = 2;
  localparam int IDX_W      = 2;
  localparam int LINE_W     = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_RD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_FILL   = 2'b01,
    OP_WB     = 2'b10,
    OP_WBFILL = 2'b11
  } op_e;

  function automatic logic [15:0] word_addr(input logic [LINE_W-1:0] line,
                                            input logic [IDX_W-1:0]  idx);
    return {line, idx, 1'b0};
  endfunction

endpackage

// File: rtl/line_fill_engine_pipe.sv
// Return pipe: tracks issued reads so each word lands in the cache when its data arrives.
module fill_return_pipe
  import line_fill_engine_pkg::*;
#(
  parameter int DEPTH = RD_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             pending
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= push;
      idx_q[0] <= push_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

  // Reads still in flight behind the output stage; the drain ends once these are gone.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | vld_q[i];
  end

endmodule

// File: rtl/line_fill_engine.sv
// Cache line fill / writeback sequencer: streams a victim line out, then streams a line in.
//   state    | meaning
//   ST_IDLE  | waiting for a start strobe with a non-zero op
//   ST_WB    | writing victim words to the banks, busy-gated
//   ST_RD    | issuing fill reads, returned words written to the cache
//   ST_DRAIN | all reads issued, waiting for the last returns
//   ST_DONE  | one-cycle done pulse, err set if the op aborted
module line_fill_engine
  import line_fill_engine_pkg::*;
#(
  parameter int WORDS  = WORDS_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [LINE_W-1:0] fill_addr,
  input  logic [LINE_W-1:0] wb_addr,
  input  logic [15:0]       cache_rdata,
  output logic [IDX_W-1:0]  word_idx,
  output logic [15:0]       fill_data,
  output logic              fill_we,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic [3:0]        mem_busy,
  input  logic              mem_err,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  op_e               op_q;
  logic [LINE_W-1:0] fill_line_q;
  logic [LINE_W-1:0] wb_line_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              err_q;

  logic              wr_go, rd_go, abort, last_word;
  logic              pipe_valid, pipe_pending;
  logic [IDX_W-1:0]  pipe_idx;

  assign wr_go     = (state_q == ST_WB) && !mem_busy[cnt_q];
  assign rd_go     = (state_q == ST_RD) && !mem_busy[cnt_q];
  assign abort     = (wr_go || rd_go) && mem_err;
  assign last_word = (cnt_q == IDX_W'(WORDS - 1));

  fill_return_pipe #(.DEPTH(RD_LAT)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .push     (rd_go && !mem_err),
    .push_idx (cnt_q),
    .out_valid(pipe_valid),
    .out_idx  (pipe_idx),
    .pending  (pipe_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      fill_line_q <= '0;
      wb_line_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
          if (start && (op_e'(op) != OP_NONE)) begin
            op_q        <= op_e'(op);
            fill_line_q <= fill_addr;
            wb_line_q   <= wb_addr;
            state_q     <= (op_e'(op) == OP_FILL) ? ST_RD : ST_WB;
          end
        end
        ST_WB: begin
          if (wr_go) begin
            if (mem_err) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else if (last_word) begin
              cnt_q   <= '0;
              state_q <= (op_q == OP_WBFILL) ? ST_RD : ST_DONE;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        ST_RD: begin
          if (rd_go) begin
            if (mem_err) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else if (last_word) begin
              state_q <= ST_DRAIN;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        // Leave as soon as nothing is queued behind the word returning this cycle.
        ST_DRAIN: if (!pipe_pending) state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    word_idx = '0;
    case (state_q)
      ST_WB:    word_idx = cnt_q;
      ST_RD:    word_idx = pipe_valid ? pipe_idx : cnt_q;
      ST_DRAIN: word_idx = pipe_valid ? pipe_idx : '0;
      default:  word_idx = '0;
    endcase
  end

  assign mem_wr    = wr_go;
  assign mem_rd    = rd_go;
  assign mem_addr  = wr_go ? word_addr(wb_line_q, cnt_q) :
                     rd_go ? word_addr(fill_line_q, cnt_q) : 16'h0000;
  assign mem_wdata = wr_go ? cache_rdata : 16'h0000;
  assign fill_we   = pipe_valid;
  assign fill_data = pipe_valid ? mem_rdata : 16'h0000;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;

endmodule

// File: doc/line_fill_engine.md
LINE_FILL_ENGINE -- requirements
Module: line_fill_engine

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning 16-bit words per cache line.
REQ-002 SHALL have parameter RD_LAT, default 2, meaning cycles from mem_rd issue to valid mem_data_in.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  command strobe from cache controller; sampled only in IDLE.
REQ-006 op  in  2  00 none, 01 fill, 10 writeback, 11 writeback-then-fill.
REQ-007 fill_addr  in  13  line address [15:3] for fill reads.
REQ-008 wb_addr  in  13  line address [15:3] for writeback (victim tag+index).
REQ-009 cache_rdata  in  16  cache word selected by word_idx, for writeback.
REQ-010 word_idx  out  2  word offset for cache read (writeback) or cache write (fill).
REQ-011 fill_data  out  16  data to cache; equals mem_data_in.
REQ-012 fill_we  out  1  cache word write enable.
REQ-013 mem_addr  out  16  {line address, word index, 1'b0}.
REQ-014 mem_wdata  out  16  equals cache_rdata.
REQ-015 mem_wr, mem_rd  out  1 each  single-cycle bank access strobes; never both high.
REQ-016 mem_rdata  in  16  bank read data, valid RD_LAT cycles after mem_rd.
REQ-017 mem_busy  in  4  per-bank busy; bank = word index.
REQ-018 mem_err  in  1  memory error for the current access.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 err  out  1  high with done when the operation aborted.

Function
REQ-022 States: IDLE, WB, RD, DRAIN, DONE.
REQ-023 IDLE: start with op 10/11 -> WB; op 01 -> RD; op 00 or start low -> IDLE; op/addresses latched on acceptance.
REQ-024 start asserted outside IDLE SHALL be ignored.
REQ-025 WB: word counter 0..WORDS-1; mem_wr asserted and counter advances only when mem_busy[counter]==0; else hold, no strobe.
REQ-026 After write of word WORDS-1: op 11 -> RD with counter cleared; op 10 -> DONE.
REQ-027 RD: mem_rd, same busy gating; each issued read pushes {valid, idx} into an RD_LAT-deep return pipe.
REQ-028 Pipe output valid SHALL assert fill_we for one cycle with word_idx = pipe idx; fill_data = mem_rdata.
REQ-029 During RD, word_idx SHALL be the pipe idx when the pipe output is valid, else the issue counter.
REQ-030 After read of word WORDS-1 -> DRAIN; DRAIN -> DONE when pipe empty and no fill_we this cycle.
REQ-031 DONE: done=1 one cycle -> IDLE; next start is accepted in IDLE the following cycle.
REQ-032 mem_err high in any issue cycle: abort remaining issues, flush pipe, -> DONE with err=1.
REQ-033 Unblocked latency (RD_LAT=2): fill done 7 cycles after acceptance, writeback 5, writeback-then-fill 11.
REQ-034 Counters SHALL wrap only via state exit; no word issued twice per operation.

Reset
REQ-035 rst SHALL force IDLE, clear counters and return pipe, latched op/addresses to 0.
REQ-036 All outputs SHALL be 0 during and immediately after reset, including mid-operation; no done pulse for an aborted operation.

Structure
REQ-037 Shared package SHALL hold state encoding, op codes (OP_NONE/FILL/WB/WBFILL), WORDS, and RD_LAT defaults.
REQ-038 Return pipe SHALL be a sub-module fill_return_pipe (RD_LAT-deep shift of {valid, idx[1:0]}, sync flush).

Verification
REQ-039 Fill, fill_addr=13'h0040, busy=0, mem_rdata=addr -> mem_rd at 0x0200/02/04/06 cycles 1-4; fill_we cycles 3-6 idx 0..3; done cycle 7.
REQ-040 Writeback, wb_addr=13'h1FFF, cache_rdata=16'hA5A0+idx -> mem_wr 0xFFF8..0xFFFE cycles 1-4; data A5A0..A5A3; done cycle 5, err=0.
REQ-041 Op 11, mem_busy[0] held high cycles 5-7 -> first read delayed to cycle 8; all 4 fill words correct; done cycle 14.
REQ-042 Fill, mem_err high on third issue -> no 4th mem_rd; done=err=1 next cycle; fill_we never for idx 2/3.
REQ-043 rst pulsed cycle 3 of fill -> all outputs 0 next edge; no done; new fill accepted cleanly after release.
REQ-044 start with op 01 during writeback, and op 00 in IDLE -> ignored; busy and counts unchanged.
